// File: rtl/tatsujin_pkg.sv
// Shared lane geometry, colours and scheduler state encoding
// for the note lane renderer.
package tatsujin_pkg;

    localparam int NUM_SLOTS  = 10;
    localparam int PIX_PER_SQ = 16;

    localparam logic [7:0] DEF_X_BASE     = 8'd10;
    localparam logic [7:0] DEF_SLOT_PITCH = 8'd14;
    localparam logic [6:0] DEF_ROW        = 7'd53;

    localparam logic [2:0] DEF_NOTE_COLOUR = 3'b100;
    localparam logic [2:0] DEF_BG_COLOUR   = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

endpackage

// File: rtl/note_draw_scheduler_square_pixel_gen.sv
// Maps a square origin and 4-bit row-major pixel index
// to the absolute framebuffer coordinate of that pixel.
module square_pixel_gen (
    input  logic [7:0] i_org_x,
    input  logic [6:0] i_org_y,
    input  logic [3:0] i_pix,
    output logic [7:0] o_x,
    output logic [6:0] o_y
);

    assign o_x = i_org_x + {6'd0, i_pix[1:0]};
    assign o_y = i_org_y + {5'd0, i_pix[3:2]};

endmodule

// File: rtl/note_draw_scheduler.sv
// Walks the 10 note slots once per frame tick, one pixel per clock.
// Define TATSUJIN_DIRTY_SKIP_EN to skip slots unchanged since last pass.
module note_draw_scheduler
    import tatsujin_pkg::*;
#(
    parameter logic [7:0] X_BASE      = DEF_X_BASE,
    parameter logic [7:0] SLOT_PITCH  = DEF_SLOT_PITCH,
    parameter logic [6:0] ROW         = DEF_ROW,
    parameter logic [2:0] NOTE_COLOUR = DEF_NOTE_COLOUR,
    parameter logic [2:0] BG_COLOUR   = DEF_BG_COLOUR
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [9:0] notes,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_slot;
    logic [3:0] r_pix;
    logic [9:0] r_snap;
    logic       r_pending;
    logic       r_overrun;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic [2:0] r_colour;

    logic       w_plot;
    logic       w_busy;
    logic       w_done;
    logic       w_load;
    logic       w_step;
    logic       w_skip;
    logic       w_last_pix;
    logic       w_last_slot;
    logic [7:0] w_org_x;
    logic [7:0] w_px;
    logic [6:0] w_py;
    logic [2:0] w_colour;

    assign w_last_pix  = (r_pix == 4'(PIX_PER_SQ - 1));
    assign w_last_slot = (r_slot == 4'(NUM_SLOTS - 1));
    assign w_org_x     = X_BASE + ({4'd0, r_slot} * SLOT_PITCH);
    assign w_colour    = r_snap[r_slot] ? NOTE_COLOUR : BG_COLOUR;

    square_pixel_gen u_pix_gen (
        .i_org_x (w_org_x),
        .i_org_y (ROW),
        .i_pix   (r_pix),
        .o_x     (w_px),
        .o_y     (w_py)
    );

`ifdef TATSUJIN_DIRTY_SKIP_EN
    logic [9:0] r_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= '0;
        end else if (r_state == DONE) begin
            r_prev <= r_snap;
        end
    end

    assign w_skip = (r_state == DRAW) && (r_snap[r_slot] == r_prev[r_slot]);
`else
    assign w_skip = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_plot      = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (frame_tick || r_pending) begin
                    w_load      = 1'b1;
                    w_state_nxt = DRAW;
                end
            end
            DRAW: begin
                w_busy = 1'b1;
                w_plot = !w_skip;
                w_step = 1'b1;
                if (w_last_slot && (w_skip || w_last_pix)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
                if (r_pending) begin
                    w_load      = 1'b1;
                    w_state_nxt = DRAW;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot <= '0;
            r_pix  <= '0;
            r_snap <= '0;
        end else if (w_load) begin
            r_slot <= '0;
            r_pix  <= '0;
            r_snap <= notes;
        end else if (w_step) begin
            if (w_skip || w_last_pix) begin
                r_pix  <= '0;
                r_slot <= w_last_slot ? 4'd0 : r_slot + 4'd1;
            end else begin
                r_pix <= r_pix + 4'd1;
            end
        end
    end

    // A tick landing on the DONE that restarts a pass becomes the next request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_load) begin
            r_pending <= (r_state == DONE) && frame_tick;
        end else if (frame_tick && (r_state != IDLE)) begin
            r_pending <= 1'b1;
            if (r_pending && (r_state == DRAW)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_colour <= '0;
        end else if (w_plot) begin
            r_x      <= w_px;
            r_y      <= w_py;
            r_colour <= w_colour;
        end
    end

    assign x          = w_plot ? w_px : r_x;
    assign y          = w_plot ? w_py : r_y;
    assign colour     = w_plot ? w_colour : r_colour;
    assign plot       = w_plot;
    assign busy       = w_busy;
    assign frame_done = w_done;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_note_draw_scheduler.sv
// Self-checking bench: per-cycle comparison against a pixel-list
// reference model of the note lane redraw.
module tb_note_draw_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [9:0] notes = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    always #5 clk = ~clk;

    note_draw_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .notes      (notes),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // kind: 0 = pixel write, 1 = skipped slot, 2 = pass complete
    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] px;
        logic [6:0] py;
        logic [2:0] pc;
    } ev_t;

    ev_t        q[$];
    logic       m_pend;
    logic       m_ovr;
    logic [9:0] m_snap;
    logic [9:0] m_prev;
    logic [7:0] m_lx;
    logic [6:0] m_ly;
    logic [2:0] m_lc;

    function automatic int changed_slots(input logic [9:0] s,
                                         input logic [9:0] p);
`ifdef TATSUJIN_DIRTY_SKIP_EN
        return $countones(s ^ p);
`else
        return 10;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        m_pend = 1'b0;
        m_ovr  = 1'b0;
        m_snap = '0;
        m_prev = '0;
        m_lx   = '0;
        m_ly   = '0;
        m_lc   = '0;
    endtask

    task automatic build(input logic [9:0] s);
        ev_t e;
        m_snap = s;
        q.delete();
        for (int sl = 0; sl < 10; sl++) begin
`ifdef TATSUJIN_DIRTY_SKIP_EN
            if (s[sl] == m_prev[sl]) begin
                e = '0;
                e.kind = 2'd1;
                q.push_back(e);
                continue;
            end
`endif
            for (int p = 0; p < 16; p++) begin
                e.kind = 2'd0;
                e.px   = 8'(10 + 14 * sl + p % 4);
                e.py   = 7'(53 + p / 4);
                e.pc   = s[sl] ? 3'b100 : 3'b000;
                q.push_back(e);
            end
        end
        e = '0;
        e.kind = 2'd2;
        q.push_back(e);
    endtask

    task automatic model_edge(input logic t, input logic [9:0] n);
        ev_t e;
        if (q.size() == 0) begin
            if (t || m_pend) begin
                build(n);
                m_pend = 1'b0;
            end
        end else begin
            e = q.pop_front();
            if (e.kind == 2'd2) begin
                m_prev = m_snap;
                if (m_pend) build(n);
                m_pend = t;
            end else if (t) begin
                if (m_pend) m_ovr = 1'b1;
                m_pend = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        logic eb;
        logic ep;
        logic ed;
        eb = (q.size() != 0);
        ep = 1'b0;
        ed = 1'b0;
        if (eb) begin
            ep = (q[0].kind == 2'd0);
            ed = (q[0].kind == 2'd2);
            if (ep) begin
                m_lx = q[0].px;
                m_ly = q[0].py;
                m_lc = q[0].pc;
            end
        end
        check("plot", plot, ep);
        check("busy", busy, eb);
        check("frame_done", frame_done, ed);
        check("overrun", overrun, m_ovr);
        check("x", x, m_lx);
        check("y", y, m_ly);
        check("colour", colour, m_lc);
    endtask

    task automatic step(input logic t, input logic [9:0] n);
        frame_tick = t;
        notes = n;
        @(posedge clk);
        model_edge(t, n);
        #1;
        frame_tick = 1'b0;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
    endtask

    task automatic wait_idle(input logic [9:0] n);
        int k;
        k = 0;
        while (busy && k < 400) begin
            step(1'b0, n);
            k++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    task automatic measure_pass(input logic [9:0] n, input string tag);
        int plots;
        int done_at;
        int chg;
        chg = changed_slots(n, m_prev);
        plots = 0;
        done_at = 0;
        step(1'b1, n);
        for (int k = 1; k <= 400; k++) begin
            if (k > 1) step(1'b0, n);
            if (plot) plots++;
            if (frame_done) begin
                done_at = k;
                break;
            end
        end
        check({tag, "_plots"}, plots, 16 * chg);
        check({tag, "_done_cycle"}, done_at, 16 * chg + (10 - chg) + 1);
        step(1'b0, n);
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        repeat (50) step(1'b0, 10'h000);

        step(1'b1, 10'h001);
        check("first_x", x, 8'd10);
        check("first_y", y, 7'd53);
        check("first_colour", colour, 3'b100);
        for (int k = 2; k <= 17; k++) begin
            step(1'b0, 10'h001);
            if (k == 16) begin
                check("slot0_last_x", x, 8'd13);
                check("slot0_last_y", y, 7'd56);
            end
`ifndef TATSUJIN_DIRTY_SKIP_EN
            if (k == 17) begin
                check("slot1_first_x", x, 8'd24);
                check("slot1_first_y", y, 7'd53);
                check("slot1_first_colour", colour, 3'b000);
            end
`endif
        end
        wait_idle(10'h001);
        step(1'b0, 10'h001);

        do_reset();
        measure_pass(10'h001, "p1");
        measure_pass(10'h001, "p1_repeat");

        step(1'b1, 10'h000);
        for (int k = 2; k < 20; k++) step(1'b0, 10'h000);
        wait_idle(10'h3FF);
        step(1'b1, 10'h3FF);
        check("redraw_colour", colour, 3'b100);
        wait_idle(10'h3FF);

        do_reset();
        step(1'b1, 10'h0AA);
        for (int k = 2; k < 50; k++) step(1'b0, 10'h0AA);
        step(1'b1, 10'h155);
        for (int k = 0; k < 400 && !frame_done; k++) step(1'b0, 10'h155);
        check("done_before_restart", frame_done, 1'b1);
        step(1'b0, 10'h155);
        check("restart_busy", busy, 1'b1);
        check("restart_overrun", overrun, 1'b0);
        wait_idle(10'h155);

        step(1'b1, 10'h00F);
        for (int k = 2; k < 50; k++) step(1'b0, 10'h00F);
        step(1'b1, 10'h0F0);
        for (int k = 51; k < 70; k++) step(1'b0, 10'h0F0);
        step(1'b1, 10'h0F0);
        check("overrun_set", overrun, 1'b1);
        wait_idle(10'h0F0);
        repeat (5) step(1'b0, 10'h0F0);
        check("overrun_sticky", overrun, 1'b1);

        do_reset();
        step(1'b1, 10'h2F0);
        for (int k = 2; k <= 80; k++) step(1'b0, 10'h2F0);
        do_reset();
        check("abort_plot", plot, 1'b0);
        check("abort_busy", busy, 1'b0);
        measure_pass(10'h2F0, "post_reset");

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 2999) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 119) == 0, 10'($urandom));
            end
        end
        wait_idle(notes);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
